// File: rtl/param_data_stack_if.sv
// param_data_stack_if: operation request and stack status bundle for param_data_stack
interface param_data_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
);
    localparam int DW = $clog2(DEPTH + 1);
    logic [2:0]       stackOP;
    logic [WIDTH-1:0] w;
    logic             clear_err;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    modport master (
        output stackOP, w, clear_err,
        input  a, b, depth, empty, full, overflow, underflow
    );
    modport slave (
        input  stackOP, w, clear_err,
        output a, b, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/param_data_stack.sv
// param_data_stack: single-cycle LIFO with stack-machine ops and sticky error flags
module param_data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input logic CLK,
    input logic reset,
    param_data_stack_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3;
    localparam logic [2:0] POP2 = 3'd4, SWAP = 3'd5, DUP = 3'd6, OVER = 3'd7;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DW-1:0]    depth_q, depth_d, need;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [AW-1:0]    t_idx, s_idx, n_idx, idx0;
    logic [WIDTH-1:0] top, sec, dat0;
    logic             full, grow, uf, of, ok, we0, we1;

    // Entry i lives at mem_q[i]; the top is at depth-1, so unaffected entries never move
    assign t_idx = AW'(depth_q - DW'(1));
    assign s_idx = AW'(depth_q - DW'(2));
    assign n_idx = AW'(depth_q);
    assign full  = depth_q == DW'(DEPTH);

    always_comb begin
        top     = depth_q >= DW'(1) ? mem_q[t_idx] : '0;
        sec     = depth_q >= DW'(2) ? mem_q[s_idx] : '0;
        need    = (bus.stackOP == POP || bus.stackOP == REPLACE || bus.stackOP == DUP) ? DW'(1) :
                  (bus.stackOP == POP2 || bus.stackOP == SWAP || bus.stackOP == OVER) ? DW'(2) : '0;
        grow    = bus.stackOP == PUSH || bus.stackOP == DUP || bus.stackOP == OVER;
        uf      = depth_q < need;
        of      = !uf && grow && full;
        ok      = !uf && !of;
        depth_d = !ok ? depth_q :
                  grow ? depth_q + DW'(1) :
                  (bus.stackOP == POP || bus.stackOP == POP2) ? depth_q - DW'(1) : depth_q;
        we0     = ok && bus.stackOP != NOP && bus.stackOP != POP;
        idx0    = grow ? n_idx : bus.stackOP == POP2 ? s_idx : t_idx;
        dat0    = bus.stackOP == DUP ? top :
                  (bus.stackOP == OVER || bus.stackOP == SWAP) ? sec : bus.w;
        we1     = ok && bus.stackOP == SWAP;
        ovf_d   = (ovf_q && !bus.clear_err) || of;
        unf_d   = (unf_q && !bus.clear_err) || uf;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset && we0) mem_q[idx0] <= dat0;
        if (!reset && we1) mem_q[s_idx] <= top;
    end

    assign bus.a         = top;
    assign bus.b         = sec;
    assign bus.depth     = depth_q;
    assign bus.empty     = depth_q == '0;
    assign bus.full      = full;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
endmodule

// File: tb/tb_param_data_stack.sv
// tb_param_data_stack: directed vectors with queued expectations checked by a monitor
module tb_param_data_stack;
    localparam int W = 16, D = 4;
    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPLACE = 3'd3;
    localparam logic [2:0] POP2 = 3'd4, SWAP = 3'd5, DUP = 3'd6, OVER = 3'd7;

    typedef struct packed {
        logic [15:0] a, b;
        logic [2:0]  d;
        logic        e, f, o, u;
    } exp_t;

    logic CLK = 1'b0, reset = 1'b0;
    int checks = 0, failures = 0;
    exp_t q[$];

    param_data_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();
    param_data_stack #(.WIDTH(W), .DEPTH(D)) dut (.CLK(CLK), .reset(reset), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", n, checks / 7, act, req);
        end
    endtask

    function automatic exp_t E(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d,
                               input logic o, input logic u);
        E = '{a: a, b: b, d: d, e: d == 0, f: d == 3'(D), o: o, u: u};
    endfunction

    task automatic step(input logic r, input logic [2:0] op, input logic [15:0] wv,
                        input logic clr, input exp_t x);
        @(negedge CLK);
        reset = r;
        bus.stackOP = op;
        bus.w = wv;
        bus.clear_err = clr;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                chk("a", 32'(bus.a), 32'(x.a));
                chk("b", 32'(bus.b), 32'(x.b));
                chk("depth", 32'(bus.depth), 32'(x.d));
                chk("empty", 32'(bus.empty), 32'(x.e));
                chk("full", 32'(bus.full), 32'(x.f));
                chk("overflow", 32'(bus.overflow), 32'(x.o));
                chk("underflow", 32'(bus.underflow), 32'(x.u));
            end
        end
    end

    initial begin
        bus.stackOP = NOP;
        bus.w = '0;
        bus.clear_err = 1'b0;
        step(1, PUSH, 16'h1111, 0, E(0, 0, 0, 0, 0));
        step(0, PUSH, 16'h0005, 0, E(16'h0005, 0, 1, 0, 0));
        step(0, PUSH, 16'h0003, 0, E(16'h0003, 16'h0005, 2, 0, 0));
        step(0, POP2, 16'h0008, 0, E(16'h0008, 0, 1, 0, 0));
        step(0, SWAP, 16'h0000, 0, E(16'h0008, 0, 1, 0, 1));
        step(0, NOP,  16'h0000, 1, E(16'h0008, 0, 1, 0, 0));
        step(1, NOP,  16'h0000, 0, E(0, 0, 0, 0, 0));
        step(0, PUSH, 16'h0001, 0, E(1, 0, 1, 0, 0));
        step(0, PUSH, 16'h0002, 0, E(2, 1, 2, 0, 0));
        step(0, PUSH, 16'h0003, 0, E(3, 2, 3, 0, 0));
        step(0, PUSH, 16'h0004, 0, E(4, 3, 4, 0, 0));
        step(0, PUSH, 16'h0009, 0, E(4, 3, 4, 1, 0));
        step(0, DUP,  16'h0000, 0, E(4, 3, 4, 1, 0));
        step(0, POP,  16'h0000, 0, E(3, 2, 3, 1, 0));
        step(1, PUSH, 16'h5555, 1, E(0, 0, 0, 0, 0));
        step(0, PUSH, 16'h7777, 0, E(16'h7777, 0, 1, 0, 0));
        step(0, PUSH, 16'h00B0, 0, E(16'h00B0, 16'h7777, 2, 0, 0));
        step(0, PUSH, 16'h00A0, 0, E(16'h00A0, 16'h00B0, 3, 0, 0));
        step(0, OVER, 16'h0000, 0, E(16'h00B0, 16'h00A0, 4, 0, 0));
        step(0, SWAP, 16'h0000, 0, E(16'h00A0, 16'h00B0, 4, 0, 0));
        step(0, REPLACE, 16'h1234, 0, E(16'h1234, 16'h00B0, 4, 0, 0));
        step(0, POP2, 16'h0042, 0, E(16'h0042, 16'h00B0, 3, 0, 0));
        step(0, POP,  16'h0000, 0, E(16'h00B0, 16'h7777, 2, 0, 0));
        step(0, POP,  16'h0000, 0, E(16'h7777, 0, 1, 0, 0));
        step(0, POP,  16'h0000, 0, E(0, 0, 0, 0, 0));
        step(0, POP,  16'h0000, 1, E(0, 0, 0, 0, 1));
        step(0, NOP,  16'h0000, 1, E(0, 0, 0, 0, 0));
        step(0, DUP,  16'h0000, 0, E(0, 0, 0, 0, 1));
        step(0, PUSH, 16'hBEEF, 0, E(16'hBEEF, 0, 1, 0, 1));
        step(0, OVER, 16'h0000, 0, E(16'hBEEF, 0, 1, 0, 1));
        step(0, NOP,  16'h0000, 0, E(16'hBEEF, 0, 1, 0, 1));
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge CLK);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
